// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer slice: FSM state encoding,
// note word field positions and the default song terminator word.
package song_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Note word layout as seen by the arranger; the sequencer never decodes it.
    localparam int unsigned ADV_BIT  = 15;
    localparam int unsigned NOTE_MSB = 14;
    localparam int unsigned NOTE_LSB = 9;
    localparam int unsigned DUR_MSB  = 8;
    localparam int unsigned DUR_LSB  = 3;

    localparam logic [15:0] END_WORD_DEFAULT = 16'h0000;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/dffr_an.sv
// Register with asynchronous active-low reset.
// Ports: clk, reset (active low, async), d (next value), q (registered value).
module dffr_an #(
    parameter int unsigned         WIDTH   = 1,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= RST_VAL;
        else        q <= d;
    end

endmodule

// File: rtl/song_addr_counter.sv
// Song / note index registers that form the ROM address.
// Ports: clk, reset (active low, async); new_song loads song_sel and clears
// the note index (takes priority over inc); inc advances the note index;
// song, note_index are the registered values; at_max flags the last note.
module song_addr_counter #(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned NOTE_BITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_song,
    input  logic [SONG_BITS-1:0] song_sel,
    input  logic                 inc,
    output logic [SONG_BITS-1:0] song,
    output logic [NOTE_BITS-1:0] note_index,
    output logic                 at_max
);

    logic [SONG_BITS-1:0] song_nxt;
    logic [NOTE_BITS-1:0] note_nxt;

    always_comb begin
        song_nxt = song;
        note_nxt = note_index;
        if (new_song) begin
            song_nxt = song_sel;
            note_nxt = '0;
        end else if (inc) begin
            note_nxt = note_index + 1'b1;
        end
    end

    dffr_an #(.WIDTH(SONG_BITS)) u_song (
        .clk(clk), .reset(reset), .d(song_nxt), .q(song)
    );

    dffr_an #(.WIDTH(NOTE_BITS)) u_note (
        .clk(clk), .reset(reset), .d(note_nxt), .q(note_index)
    );

    assign at_max = &note_index;

endmodule

// File: rtl/song_sequencer.sv
// Reads note words from an external synchronous song ROM and hands them to
// the note arranger one at a time, waiting for note_done between words.
// Ports: clk, reset (active low, async); play allows issuing; new_song with
// song_sel restarts at note 0 of the chosen song; rom_addr/rom_data talk to
// the ROM (1-cycle read latency); note_to_load/load_new_note/note_done form
// the arranger handshake; song_done pulses at end of song; busy is high
// while fetching, issuing or waiting on the arranger.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int unsigned SONG_BITS = 2,
    parameter int unsigned NOTE_BITS = 5,
    parameter logic [15:0] END_WORD  = END_WORD_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           new_song,
    input  logic [SONG_BITS-1:0]           song_sel,
    output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
    input  logic [15:0]                    rom_data,
    input  logic                           note_done,
    output logic [15:0]                    note_to_load,
    output logic                           load_new_note,
    output logic                           song_done,
    output logic                           busy
);

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           state_q;
    logic [15:0]          note_nxt;
    logic                 load_nxt;
    logic                 done_nxt;
    logic                 inc;
    logic                 at_max;
    logic [SONG_BITS-1:0] song;
    logic [NOTE_BITS-1:0] note_index;

    song_addr_counter #(
        .SONG_BITS(SONG_BITS),
        .NOTE_BITS(NOTE_BITS)
    ) u_addr (
        .clk        (clk),
        .reset      (reset),
        .new_song   (new_song),
        .song_sel   (song_sel),
        .inc        (inc),
        .song       (song),
        .note_index (note_index),
        .at_max     (at_max)
    );

    // Both halves come straight from registers, so the address is registered.
    assign rom_addr = {song, note_index};

    dffr_an #(.WIDTH(3)) u_state (
        .clk(clk), .reset(reset), .d(state_nxt), .q(state_q)
    );
    assign state = state_t'(state_q);

    always_comb begin
        state_nxt = state;
        note_nxt  = note_to_load;
        load_nxt  = 1'b0;
        done_nxt  = 1'b0;
        inc       = 1'b0;
        // new_song abandons whatever is in flight, including a same-cycle note_done.
        if (new_song) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (play) state_nxt = ST_FETCH;
                end
                ST_FETCH: begin
                    state_nxt = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (rom_data == END_WORD) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        note_nxt  = rom_data;
                        load_nxt  = 1'b1;
                        state_nxt = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (note_done) begin
                        if (at_max) begin
                            done_nxt  = 1'b1;
                            state_nxt = ST_DONE;
                        end else begin
                            inc       = 1'b1;
                            state_nxt = play ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    dffr_an #(.WIDTH(16)) u_note_word (
        .clk(clk), .reset(reset), .d(note_nxt), .q(note_to_load)
    );

    dffr_an #(.WIDTH(1)) u_load (
        .clk(clk), .reset(reset), .d(load_nxt), .q(load_new_note)
    );

    dffr_an #(.WIDTH(1)) u_song_done (
        .clk(clk), .reset(reset), .d(done_nxt), .q(song_done)
    );

    assign busy = state_is_busy(state);

endmodule
